// File: rtl/i2c_bit_ctrl_if.sv
// Command, timer and open-drain line bundle between the I2C bit sequencer and its neighbours.
// slave = sequencer view, master = byte layer / timer / pad view.
interface i2c_bit_ctrl_if #(parameter int SIZE = 8);
    logic            cmd_valid;
    logic [2:0]      cmd;
    logic            din;
    logic [SIZE-1:0] ticks;
    logic            cmd_ready;
    logic            done;
    logic            dout;
    logic            bus_busy;
    logic            tmr_start;
    logic            tmr_stop;
    logic [SIZE-1:0] tmr_ticks;
    logic            tmr_out;
    logic            scl_in;
    logic            sda_in;
    logic            scl_oe;
    logic            sda_oe;

    modport slave (
        input  cmd_valid, cmd, din, ticks, tmr_out, scl_in, sda_in,
        output cmd_ready, done, dout, bus_busy, tmr_start, tmr_stop, tmr_ticks, scl_oe, sda_oe
    );

    modport master (
        output cmd_valid, cmd, din, ticks, tmr_out, scl_in, sda_in,
        input  cmd_ready, done, dout, bus_busy, tmr_start, tmr_stop, tmr_ticks, scl_oe, sda_oe
    );
endinterface

// File: rtl/i2c_bit_ctrl.sv
// I2C bit sequencer: runs START/STOP/WRITE/READ as four timer-paced quarter phases.
// Optional build macro I2C_CLK_STRETCH_EN lets a slave hold SCL low to extend phase B.
//
//  state | meaning
//  IDLE  | waiting for a command, cmd_ready high, timer held
//  PH_A  | first quarter of the bit
//  PH_B  | second quarter, SCL released for data bits (stretchable)
//  PH_C  | third quarter, READ samples SDA at its end
//  PH_D  | last quarter, Done issued when it expires
module i2c_bit_ctrl #(
    parameter int SIZE = 8
) (
    input logic           clk,
    input logic           rst,
    i2c_bit_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PH_A, PH_B, PH_C, PH_D} state_t;

    localparam logic [2:0] CMD_START = 3'd1;
    localparam logic [2:0] CMD_STOP  = 3'd2;
    localparam logic [2:0] CMD_WRITE = 3'd3;
    localparam logic [2:0] CMD_READ  = 3'd4;

    state_t          state;
    state_t          next_ph;
    logic [2:0]      cmd_q;
    logic            din_q;
    logic [SIZE-1:0] ticks_clamped;
    logic            is_bit_cmd;
    logic            stretch_hold;

    // {scl_oe, sda_oe} for a given command and phase
    function automatic logic [1:0] phase_lines(input logic [2:0] c, input logic d, input state_t ph);
        logic [1:0] r;
        r = 2'b00;
        case (c)
            CMD_START: r = (ph == PH_C) ? 2'b01 : (ph == PH_D) ? 2'b11 : 2'b00;
            CMD_STOP:  r = (ph == PH_A) ? 2'b11 : (ph == PH_D) ? 2'b00 : 2'b01;
            CMD_WRITE: r = {(ph == PH_A) || (ph == PH_D), ~d};
            CMD_READ:  r = {(ph == PH_A) || (ph == PH_D), 1'b0};
            default:   r = 2'b00;
        endcase
        return r;
    endfunction

    assign ticks_clamped = (bus.ticks == '0) ? SIZE'(1) : bus.ticks;
    assign is_bit_cmd    = (bus.cmd >= CMD_START) && (bus.cmd <= CMD_READ);

`ifdef I2C_CLK_STRETCH_EN
    assign stretch_hold = (state == PH_B) && !bus.scl_in;
`else
    assign stretch_hold = 1'b0;
`endif

    always_comb begin
        next_ph = IDLE;
        case (state)
            PH_A:    next_ph = PH_B;
            PH_B:    next_ph = PH_C;
            PH_C:    next_ph = PH_D;
            default: next_ph = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cmd_q         <= 3'd0;
            din_q         <= 1'b0;
            bus.cmd_ready <= 1'b1;
            bus.done      <= 1'b0;
            bus.dout      <= 1'b0;
            bus.bus_busy  <= 1'b0;
            bus.tmr_start <= 1'b0;
            bus.tmr_stop  <= 1'b1;
            bus.tmr_ticks <= SIZE'(1);
            bus.scl_oe    <= 1'b0;
            bus.sda_oe    <= 1'b0;
        end else begin
            bus.done      <= 1'b0;
            bus.tmr_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        cmd_q         <= bus.cmd;
                        din_q         <= bus.din;
                        bus.tmr_ticks <= ticks_clamped;
                        if (is_bit_cmd) begin
                            state                    <= PH_A;
                            bus.cmd_ready            <= 1'b0;
                            bus.tmr_start            <= 1'b1;
                            bus.tmr_stop             <= 1'b0;
                            {bus.scl_oe, bus.sda_oe} <= phase_lines(bus.cmd, bus.din, PH_A);
                        end else begin
                            bus.done <= 1'b1;
                        end
                    end
                end
                PH_A, PH_B, PH_C: begin
                    bus.tmr_stop <= stretch_hold;
                    if (bus.tmr_out) begin
                        state                    <= next_ph;
                        bus.tmr_start            <= 1'b1;
                        bus.tmr_stop             <= 1'b0;
                        {bus.scl_oe, bus.sda_oe} <= phase_lines(cmd_q, din_q, next_ph);
                        if ((state == PH_C) && (cmd_q == CMD_READ))
                            bus.dout <= bus.sda_in;
                    end
                end
                PH_D: begin
                    if (bus.tmr_out) begin
                        state         <= IDLE;
                        bus.done      <= 1'b1;
                        bus.tmr_stop  <= 1'b1;
                        bus.cmd_ready <= 1'b1;
                        if (cmd_q == CMD_START)
                            bus.bus_busy <= 1'b1;
                        else if (cmd_q == CMD_STOP)
                            bus.bus_busy <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.cmd_ready <= 1'b1;
                    bus.tmr_stop  <= 1'b1;
                end
            endcase
        end
    end
endmodule
